// File: rtl/mc_ctrl_if.sv
// Control/status bundle between the multi-cycle sequencer and the MIPS datapath/memory.
// master = sequencer side, slave = datapath side.
interface mc_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemAck;
  logic       MemReq;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic [1:0] PCSrc;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       ExtOp;
  logic       InstrDone;
  logic       Illegal;

  modport master (
    input  Op, Funct, Zero, MemAck,
    output MemReq, IorD, MemWrite, IRWrite, PCWrite, PCSrc, RegWrite, RegDst,
           MemtoReg, ALUSrcA, ALUSrcB, ALUOp, ExtOp, InstrDone, Illegal
  );

  modport slave (
    output Op, Funct, Zero, MemAck,
    input  MemReq, IorD, MemWrite, IRWrite, PCWrite, PCSrc, RegWrite, RegDst,
           MemtoReg, ALUSrcA, ALUSrcB, ALUOp, ExtOp, InstrDone, Illegal
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control sequencer: fetch/decode/execute/memory/write-back with a
// req/ack memory handshake. Outputs are pure state decodes (plus MemAck/Zero), so reset clears them at once.
module mc_ctrl (
  input  logic     clk,
  input  logic     Rst_n,
  mc_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_IMMEX, S_IMMWB, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t     state;
  state_t     nxt;
  logic [5:0] op_q;

  // Opcode is captured in DECODE so later states never depend on IR timing.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= S_INIT;
      op_q  <= 6'h00;
    end else begin
      state <= nxt;
      if (state == S_DECODE) op_q <= bus.Op;
    end
  end

  always_comb begin
    nxt           = state;
    bus.MemReq    = 1'b0;
    bus.IorD      = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.PCWrite   = 1'b0;
    bus.PCSrc     = 2'b00;
    bus.RegWrite  = 1'b0;
    bus.RegDst    = 1'b0;
    bus.MemtoReg  = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = 2'b00;
    bus.ALUOp     = 2'b00;
    bus.ExtOp     = 1'b0;
    bus.InstrDone = 1'b0;
    bus.Illegal   = 1'b0;

    case (state)
      S_INIT: nxt = S_FETCH;
      S_FETCH: begin
        bus.MemReq  = 1'b1;
        bus.ALUSrcB = 2'b01;
        if (bus.MemAck) begin
          bus.IRWrite = 1'b1;
          bus.PCWrite = 1'b1;
          nxt         = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.ALUSrcB = 2'b11;
        bus.ExtOp   = 1'b1;
        case (bus.Op)
          OP_RTYPE:       nxt = S_EXEC;
          OP_LW, OP_SW:   nxt = S_MEMADR;
          OP_ADDI, OP_ORI: nxt = S_IMMEX;
          OP_BEQ, OP_BNE: nxt = S_BRANCH;
          OP_J:           nxt = S_JUMP;
          default:        nxt = S_HALT;
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.ExtOp   = 1'b1;
        nxt         = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.MemReq = 1'b1;
        bus.IorD   = 1'b1;
        if (bus.MemAck) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        bus.RegWrite  = 1'b1;
        bus.MemtoReg  = 1'b1;
        bus.InstrDone = 1'b1;
        nxt           = S_FETCH;
      end
      S_MEMWR: begin
        bus.MemReq   = 1'b1;
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        if (bus.MemAck) begin
          bus.InstrDone = 1'b1;
          nxt           = S_FETCH;
        end
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
        nxt         = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegWrite  = 1'b1;
        bus.RegDst    = 1'b1;
        bus.InstrDone = 1'b1;
        nxt           = S_FETCH;
      end
      S_IMMEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        if (op_q == OP_ORI) begin
          bus.ALUOp = 2'b11;
        end else begin
          bus.ExtOp = 1'b1;
        end
        nxt = S_IMMWB;
      end
      S_IMMWB: begin
        bus.RegWrite  = 1'b1;
        bus.InstrDone = 1'b1;
        nxt           = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUOp     = 2'b01;
        bus.PCSrc     = 2'b01;
        bus.InstrDone = 1'b1;
        bus.PCWrite   = (op_q == OP_BNE) ? ~bus.Zero : bus.Zero;
        nxt           = S_FETCH;
      end
      S_JUMP: begin
        bus.PCWrite   = 1'b1;
        bus.PCSrc     = 2'b10;
        bus.InstrDone = 1'b1;
        nxt           = S_FETCH;
      end
      S_HALT: bus.Illegal = 1'b1;
      default: nxt = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: each cycle's expected output word is queued with its stimulus
// and compared at the falling edge.
module tb_mc_ctrl;

  typedef struct packed {
    logic       ack;
    logic       zero;
    logic [5:0] op;
  } stim_t;

  // {MemReq,IorD,MemWrite,IRWrite,PCWrite,PCSrc,RegWrite,RegDst,MemtoReg,ALUSrcA,ALUSrcB,ALUOp,ExtOp,InstrDone,Illegal}
  localparam logic [17:0] V_ZERO  = 18'd0;
  localparam logic [17:0] V_FW    = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0};
  localparam logic [17:0] V_FA    = {1'b1,1'b0,1'b0,1'b1,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0};
  localparam logic [17:0] V_DEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,1'b1,1'b0,1'b0};
  localparam logic [17:0] V_MADR  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b1,1'b0,1'b0};
  localparam logic [17:0] V_MRD   = {1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0};
  localparam logic [17:0] V_MWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,1'b1,1'b0};
  localparam logic [17:0] V_MWR   = {1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0};
  localparam logic [17:0] V_MWRD  = {1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,1'b0};
  localparam logic [17:0] V_EXEC  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,1'b0,1'b0,1'b0};
  localparam logic [17:0] V_ALUWB = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,1'b0};
  localparam logic [17:0] V_ADDI  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b1,1'b0,1'b0};
  localparam logic [17:0] V_ORI   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,2'b10,2'b11,1'b0,1'b0,1'b0};
  localparam logic [17:0] V_IMMWB = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,1'b0};
  localparam logic [17:0] V_BRN   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b0,1'b1,1'b0};
  localparam logic [17:0] V_BRT   = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b0,1'b1,1'b0};
  localparam logic [17:0] V_JMP   = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,1'b0};
  localparam logic [17:0] V_HALT  = 18'd1;

  logic clk = 1'b0;
  logic Rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [17:0] sb[$];
  stim_t       st[$];

  mc_ctrl_if bus ();

  mc_ctrl u_dut (
    .clk   (clk),
    .Rst_n (Rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] outs();
    return {bus.MemReq, bus.IorD, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.PCSrc,
            bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
            bus.ExtOp, bus.InstrDone, bus.Illegal};
  endfunction

  task automatic push(input logic [17:0] e, input logic ack, input logic z, input logic [5:0] op);
    sb.push_back(e);
    st.push_back({ack, z, op});
  endtask

  task automatic push_fetch(input int waits, input logic [5:0] op);
    for (int i = 0; i < waits; i++) push(V_FW, 1'b0, 1'b0, op);
    push(V_FA, 1'b1, 1'b0, op);
  endtask

  // Called just after a rising edge: drive one cycle, sample mid-cycle, advance.
  task automatic drive_sample(input stim_t s, output logic [17:0] act);
    bus.MemAck = s.ack;
    bus.Zero   = s.zero;
    bus.Op     = s.op;
    @(negedge clk);
    act = outs();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] act, e;
    Rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (outs() !== V_ZERO) begin
      n_err++;
      $display("FAIL reset_hold: got %b want %b", outs(), V_ZERO);
    end
    @(posedge clk);
    #1;
    Rst_n = 1'b1;
    push(V_ZERO, 1'b0, 1'b0, 6'h00);
    while (sb.size() > 0) begin
      drive_sample(st.pop_front(), act);
      e = sb.pop_front();
      n_cmp++;
      if (act !== e) begin n_err++; $display("FAIL reset_init: got %b want %b", act, e); end
    end
  endtask

  task automatic test_add();
    logic [17:0] act, e;
    int c = 0;
    push_fetch(0, 6'h3F);
    push(V_DEC, 1'b0, 1'b0, 6'h00);
    push(V_EXEC, 1'b0, 1'b0, 6'h00);
    push(V_ALUWB, 1'b0, 1'b0, 6'h00);
    while (sb.size() > 0) begin
      drive_sample(st.pop_front(), act);
      e = sb.pop_front();
      c++;
      n_cmp++;
      if (act !== e) begin n_err++; $display("FAIL add cyc%0d: got %b want %b", c, act, e); end
    end
  endtask

  task automatic test_lw_wait();
    logic [17:0] act, e;
    int c = 0;
    push_fetch(3, 6'h23);
    push(V_DEC, 1'b0, 1'b0, 6'h23);
    push(V_MADR, 1'b1, 1'b0, 6'h23);
    for (int i = 0; i < 3; i++) push(V_MRD, 1'b0, 1'b0, 6'h23);
    push(V_MRD, 1'b1, 1'b0, 6'h23);
    push(V_MWB, 1'b0, 1'b0, 6'h23);
    while (sb.size() > 0) begin
      drive_sample(st.pop_front(), act);
      e = sb.pop_front();
      c++;
      n_cmp++;
      if (act !== e) begin n_err++; $display("FAIL lw cyc%0d: got %b want %b", c, act, e); end
    end
  endtask

  task automatic test_sw();
    logic [17:0] act, e;
    int c = 0;
    push_fetch(0, 6'h2B);
    push(V_DEC, 1'b0, 1'b0, 6'h2B);
    push(V_MADR, 1'b0, 1'b0, 6'h2B);
    push(V_MWR, 1'b0, 1'b0, 6'h2B);
    push(V_MWRD, 1'b1, 1'b0, 6'h2B);
    while (sb.size() > 0) begin
      drive_sample(st.pop_front(), act);
      e = sb.pop_front();
      c++;
      n_cmp++;
      if (act !== e) begin n_err++; $display("FAIL sw cyc%0d: got %b want %b", c, act, e); end
    end
  endtask

  task automatic test_branch();
    logic [17:0] act, e;
    int c = 0;
    logic [5:0] op;
    logic       z;
    for (int k = 0; k < 4; k++) begin
      op = (k < 2) ? 6'h04 : 6'h05;
      z  = (k % 2 == 0);
      push_fetch(0, op);
      push(V_DEC, 1'b0, 1'b0, op);
      push(((op == 6'h04) == z) ? V_BRT : V_BRN, 1'b0, z, op);
    end
    while (sb.size() > 0) begin
      drive_sample(st.pop_front(), act);
      e = sb.pop_front();
      c++;
      n_cmp++;
      if (act !== e) begin n_err++; $display("FAIL branch cyc%0d: got %b want %b", c, act, e); end
    end
  endtask

  task automatic test_jump();
    logic [17:0] act, e;
    int c = 0;
    push_fetch(0, 6'h02);
    push(V_DEC, 1'b0, 1'b0, 6'h02);
    push(V_JMP, 1'b0, 1'b0, 6'h02);
    push(V_FW, 1'b0, 1'b0, 6'h02);
    while (sb.size() > 0) begin
      drive_sample(st.pop_front(), act);
      e = sb.pop_front();
      c++;
      n_cmp++;
      if (act !== e) begin n_err++; $display("FAIL jump cyc%0d: got %b want %b", c, act, e); end
    end
  endtask

  task automatic test_imm();
    logic [17:0] act, e;
    int c = 0;
    push_fetch(1, 6'h0D);
    push(V_DEC, 1'b0, 1'b0, 6'h0D);
    push(V_ORI, 1'b0, 1'b0, 6'h0D);
    push(V_IMMWB, 1'b0, 1'b0, 6'h0D);
    push_fetch(0, 6'h08);
    push(V_DEC, 1'b0, 1'b0, 6'h08);
    push(V_ADDI, 1'b0, 1'b0, 6'h08);
    push(V_IMMWB, 1'b0, 1'b0, 6'h08);
    while (sb.size() > 0) begin
      drive_sample(st.pop_front(), act);
      e = sb.pop_front();
      c++;
      n_cmp++;
      if (act !== e) begin n_err++; $display("FAIL imm cyc%0d: got %b want %b", c, act, e); end
    end
  endtask

  task automatic test_illegal();
    logic [17:0] act, e;
    int c = 0;
    push_fetch(0, 6'h3F);
    push(V_DEC, 1'b0, 1'b0, 6'h3F);
    for (int i = 0; i < 20; i++)
      push(V_HALT, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
    while (sb.size() > 0) begin
      drive_sample(st.pop_front(), act);
      e = sb.pop_front();
      c++;
      n_cmp++;
      if (act !== e) begin n_err++; $display("FAIL halt cyc%0d: got %b want %b", c, act, e); end
    end
  endtask

  task automatic test_reset_abort();
    logic [17:0] act, e;
    int c = 0;
    // Leave HALT through reset; Illegal must clear without waiting for a clock.
    #2 Rst_n = 1'b0;
    #1;
    n_cmp++;
    if (outs() !== V_ZERO) begin n_err++; $display("FAIL halt_reset_async: got %b want %b", outs(), V_ZERO); end
    @(posedge clk);
    #1;
    Rst_n = 1'b1;
    push(V_ZERO, 1'b0, 1'b0, 6'h2B);
    push_fetch(0, 6'h2B);
    push(V_DEC, 1'b0, 1'b0, 6'h2B);
    push(V_MADR, 1'b0, 1'b0, 6'h2B);
    push(V_MWR, 1'b0, 1'b0, 6'h2B);
    push(V_MWR, 1'b0, 1'b0, 6'h2B);
    while (sb.size() > 0) begin
      drive_sample(st.pop_front(), act);
      e = sb.pop_front();
      c++;
      n_cmp++;
      if (act !== e) begin n_err++; $display("FAIL sw_pre_abort cyc%0d: got %b want %b", c, act, e); end
    end
    n_cmp++;
    if (bus.MemReq !== 1'b1) begin n_err++; $display("FAIL sw_wait_req: got %b want 1", bus.MemReq); end
    #2 Rst_n = 1'b0;
    #1;
    n_cmp++;
    if (outs() !== V_ZERO) begin n_err++; $display("FAIL sw_abort_async: got %b want %b", outs(), V_ZERO); end
    @(posedge clk);
    #1;
    n_cmp++;
    if (outs() !== V_ZERO) begin n_err++; $display("FAIL sw_abort_next: got %b want %b", outs(), V_ZERO); end
    Rst_n = 1'b1;
    c = 0;
    push(V_ZERO, 1'b0, 1'b0, 6'h00);
    push_fetch(1, 6'h00);
    push(V_DEC, 1'b0, 1'b0, 6'h00);
    push(V_EXEC, 1'b0, 1'b0, 6'h00);
    push(V_ALUWB, 1'b0, 1'b0, 6'h00);
    while (sb.size() > 0) begin
      drive_sample(st.pop_front(), act);
      e = sb.pop_front();
      c++;
      n_cmp++;
      if (act !== e) begin n_err++; $display("FAIL restart cyc%0d: got %b want %b", c, act, e); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n      = 1'b0;
    bus.Op     = 6'h00;
    bus.Funct  = 6'h20;
    bus.Zero   = 1'b0;
    bus.MemAck = 1'b0;
    test_reset();
    test_add();
    test_lw_wait();
    test_sw();
    test_branch();
    test_jump();
    test_imm();
    test_illegal();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
